// File: rtl/filter_pkg.sv
// Shared types and helpers for the filter window scheduler.
package filter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KRST,
    ST_KGEN,
    ST_RUN,
    ST_FIN
  } state_e;

  localparam int DEF_SIZE  = 5;
  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;
  localparam int DEF_XW    = $clog2(DEF_IMG_W);
  localparam int DEF_YW    = $clog2(DEF_IMG_H);

  // Half kernel edge: window extends this far either side of its centre.
  function automatic int half_of(input int size);
    return (size - 1) / 2;
  endfunction

  // Coordinate width, never below one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order (x, y) counter; wraps to (0,0) after the last position.
module raster_counter import filter_pkg::*; #(
  parameter int W = 8,
  parameter int H = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [cw(W)-1:0] x,
  output logic [cw(H)-1:0] y,
  output logic             last
);
  localparam int XW = cw(W);
  localparam int YW = cw(H);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_end, y_end;

  assign x_end = (x_q == XW'(W - 1));
  assign y_end = (y_q == YW'(H - 1));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (inc) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_end ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = x_end & y_end;

endmodule

// File: rtl/filter_sched.sv
// Frame scheduler: kernel generation, line-buffer fill and window issue
// for a SIZE x SIZE convolution over an IMG_W x IMG_H raster stream.
module filter_sched import filter_pkg::*; #(
  parameter int SIZE  = DEF_SIZE,
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 kern_reset,
  output logic                 kern_enable,
  input  logic                 kern_done,
  input  logic                 pix_in_valid,
  output logic                 pix_in_ready,
  output logic                 line_wr_en,
  output logic [cw(SIZE)-1:0]  line_wr_row,
  output logic [cw(IMG_W)-1:0] line_wr_col,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic [cw(IMG_W)-1:0] win_x,
  output logic [cw(IMG_H)-1:0] win_y,
  output logic                 win_border
);
  localparam int H  = half_of(SIZE);
  localparam int XW = cw(IMG_W);
  localparam int YW = cw(IMG_H);
  localparam int RW = cw(SIZE);

  localparam logic [XW:0] HX   = (XW+1)'(H);
  localparam logic [YW:0] HY   = (YW+1)'(H);
  localparam logic [XW:0] XMAX = (XW+1)'(IMG_W - 1);
  localparam logic [YW:0] YMAX = (YW+1)'(IMG_H - 1);

  state_e state_q, state_d;
  logic   exh_q, exh_d;
  logic   wv_q, wv_d;
  logic   wb_q, wb_d;

  logic [XW-1:0] ix, ox;
  logic [YW-1:0] iy, oy;
  logic          in_last, out_last;
  logic          in_hs, win_hs, run, cnt_clear;

  logic [XW:0] ix_w, ox_w, ox_h, tx;
  logic [YW:0] iy_w, oy_w, oy_h, ty;
  logic        avail, border;

  assign run       = (state_q == ST_RUN);
  assign cnt_clear = ~run;

  raster_counter #(.W(IMG_W), .H(IMG_H)) u_in_cnt (
    .clk(clk), .reset(reset), .inc(in_hs), .clear(cnt_clear),
    .x(ix), .y(iy), .last(in_last)
  );

  raster_counter #(.W(IMG_W), .H(IMG_H)) u_out_cnt (
    .clk(clk), .reset(reset), .inc(win_hs), .clear(cnt_clear),
    .x(ox), .y(oy), .last(out_last)
  );

  // One extra bit on every coordinate so +H and the compares never wrap.
  assign ix_w = {1'b0, ix};
  assign iy_w = {1'b0, iy};
  assign ox_w = {1'b0, ox};
  assign oy_w = {1'b0, oy};
  assign ox_h = ox_w + HX;
  assign oy_h = oy_w + HY;
  assign tx   = (ox_h > XMAX) ? XMAX : ox_h;
  assign ty   = (oy_h > YMAX) ? YMAX : oy_h;

  // Counters only ever see pixels from earlier cycles, so this is "already accepted".
  assign avail  = exh_q | (iy_w > ty) | ((iy_w == ty) & (ix_w > tx));
  assign border = (ox_w < HX) | (oy_w < HY) | (ox_h > XMAX) | (oy_h > YMAX);

  assign pix_in_ready = run & ~exh_q & (iy_w <= oy_h);
  assign in_hs        = pix_in_valid & pix_in_ready;
  assign win_hs       = wv_q & win_ready;

  assign line_wr_en  = in_hs;
  assign line_wr_row = RW'(32'(iy) % 32'(SIZE));
  assign line_wr_col = ix;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_KRST;
      ST_KRST: state_d = ST_KGEN;
      ST_KGEN: if (kern_done) state_d = ST_RUN;
      ST_RUN:  if (win_hs && out_last) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    exh_d = exh_q;
    if (!run)                exh_d = 1'b0;
    else if (in_hs && in_last) exh_d = 1'b1;
  end

  // A window is offered only from an idle slot, so x/y/border never move under a stall.
  always_comb begin
    wv_d = wv_q;
    wb_d = wb_q;
    if (!run || win_hs) begin
      wv_d = 1'b0;
      wb_d = 1'b0;
    end else if (!wv_q && avail) begin
      wv_d = 1'b1;
      wb_d = border;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      exh_q   <= 1'b0;
      wv_q    <= 1'b0;
      wb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      exh_q   <= exh_d;
      wv_q    <= wv_d;
      wb_q    <= wb_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_FIN);
  assign kern_reset  = (state_q == ST_KRST);
  assign kern_enable = (state_q == ST_KGEN);
  assign win_valid   = wv_q;
  assign win_x       = ox;
  assign win_y       = oy;
  assign win_border  = wb_q;

endmodule

// File: tb/tb_filter_sched.sv
// Scoreboard bench for filter_sched at SIZE=5, 8x6 image.
module tb_filter_sched;
  localparam int SIZE = 5;
  localparam int W    = 8;
  localparam int HT   = 6;
  localparam int KC   = 4;

  logic clk = 1'b0;
  logic rst_n, start, kern_done, pix_in_valid, win_ready;
  logic busy, done, kern_reset, kern_enable, pix_in_ready, line_wr_en;
  logic win_valid, win_border;
  logic [2:0] line_wr_row, line_wr_col, win_x, win_y;
  logic [19:0] outs;

  always #5 clk = ~clk;

  filter_sched #(.SIZE(SIZE), .IMG_W(W), .IMG_H(HT)) dut (
    .clk(clk), .reset(rst_n), .start(start), .busy(busy), .done(done),
    .kern_reset(kern_reset), .kern_enable(kern_enable), .kern_done(kern_done),
    .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready),
    .line_wr_en(line_wr_en), .line_wr_row(line_wr_row), .line_wr_col(line_wr_col),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_x(win_x), .win_y(win_y), .win_border(win_border)
  );

  assign outs = {busy, done, kern_reset, kern_enable, pix_in_ready, line_wr_en,
                 line_wr_row, line_wr_col, win_valid, win_x, win_y, win_border};

  typedef struct {int x; int y; bit b;} win_t;
  win_t exp_q[$];

  int vecs = 0;
  int errs = 0;
  int r_nwin, r_ndone, r_first_acc, r_acc, r_row3, r_krst, r_ken, r_stalls;
  bit r_aborted;

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; kern_done = 1'b0; pix_in_valid = 1'b0; win_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // mode 0: always ready, 1: random valid/ready, 2: window side never ready
  task automatic run_frame(input int mode, input bit hold_start, input bit abort32,
                           input bit may_expire, input int budget);
    int ix, iy, cyc, px, py, tx, ty, er;
    bit pstall, pb;
    win_t w;
    ix = 0; iy = 0; cyc = 0; pstall = 0; px = 0; py = 0; pb = 0;
    r_nwin = 0; r_ndone = 0; r_first_acc = -1; r_acc = 0; r_row3 = 0;
    r_krst = 0; r_ken = 0; r_stalls = 0; r_aborted = 0;
    exp_q.delete();
    for (int y = 0; y < HT; y++)
      for (int x = 0; x < W; x++) begin
        w.x = x; w.y = y;
        w.b = (x inside {0, 1, 6, 7}) || (y inside {0, 1, 4, 5});
        exp_q.push_back(w);
      end
    start = 1'b1;
    pix_in_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
    win_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    while (r_ndone == 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (abort32 && win_valid === 1'b1 && win_x == 3'd3 && win_y == 3'd2) begin
        rst_n = 1'b0;
        r_aborted = 1;
        break;
      end
      if (kern_reset === 1'b1) r_krst++;
      if (kern_enable === 1'b1) begin
        r_ken++;
        if (r_ken == KC) kern_done = 1'b1;
      end
      if (pstall) begin
        vecs++;
        if (win_valid !== 1'b1 || 32'(win_x) !== px || 32'(win_y) !== py || win_border !== pb) begin
          errs++;
          $display("FAIL stall_hold got v=%b (%0d,%0d) b=%b exp v=1 (%0d,%0d) b=%b",
                   win_valid, win_x, win_y, win_border, px, py, pb);
        end
      end
      pstall = 0;
      if (win_valid === 1'b1) begin
        if (r_first_acc < 0) r_first_acc = r_acc;
        tx = (int'(win_x) + 2 > W - 1) ? W - 1 : int'(win_x) + 2;
        ty = (int'(win_y) + 2 > HT - 1) ? HT - 1 : int'(win_y) + 2;
        vecs++;
        if (ty * W + tx >= r_acc) begin
          errs++;
          $display("FAIL win_early window (%0d,%0d) accepted %0d need > %0d",
                   win_x, win_y, r_acc, ty * W + tx);
        end
        if (win_ready === 1'b1) begin
          vecs++;
          if (exp_q.size() == 0) begin
            errs++;
            $display("FAIL extra_window got (%0d,%0d) exp none", win_x, win_y);
          end else begin
            w = exp_q.pop_front();
            if (32'(win_x) !== w.x || 32'(win_y) !== w.y || win_border !== w.b) begin
              errs++;
              $display("FAIL window got (%0d,%0d) b=%b exp (%0d,%0d) b=%b",
                       win_x, win_y, win_border, w.x, w.y, w.b);
            end
          end
          r_nwin++;
        end else begin
          pstall = 1; px = win_x; py = win_y; pb = win_border; r_stalls++;
        end
      end
      if (line_wr_en === 1'b1) begin
        er = iy % SIZE;
        vecs++;
        if (32'(line_wr_col) !== ix || 32'(line_wr_row) !== er) begin
          errs++;
          $display("FAIL line_wr got col=%0d row=%0d exp col=%0d row=%0d",
                   line_wr_col, line_wr_row, ix, er);
        end
        if (iy == 3) r_row3++;
        r_acc++;
        if (ix == W - 1) begin ix = 0; iy++; end else ix++;
      end
      if (done === 1'b1) r_ndone++;
      @(posedge clk);
      #1;
      start = hold_start;
      kern_done = 1'b0;
      pix_in_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      win_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    if (!r_aborted && r_ndone == 0 && !may_expire) begin
      vecs++; errs++;
      $display("FAIL frame_timeout got no done after %0d cycles exp done", cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; kern_done = 1'b0; pix_in_valid = 1'b1; win_ready = 1'b1;
    repeat (2) @(negedge clk);
    vecs++;
    if (outs !== '0) begin errs++; $display("FAIL reset_outs got %h exp 0", outs); end
    @(posedge clk); #1 start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    vecs++;
    if (busy !== 1'b0) begin errs++; $display("FAIL idle_after_reset got busy=%b exp 0", busy); end
  endtask

  task automatic test_kgen();
    int krst, ken;
    krst = 0; ken = 0;
    do_reset();
    start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (kern_reset === 1'b1) krst++;
      if (kern_enable === 1'b1) begin ken++; if (ken == KC) kern_done = 1'b1; end
      @(posedge clk); #1 start = 1'b0; kern_done = 1'b0;
    end
    @(negedge clk);
    vecs++;
    if (krst != 1) begin errs++; $display("FAIL kern_reset_pulses got %0d exp 1", krst); end
    vecs++;
    if (ken != KC) begin errs++; $display("FAIL kern_enable_cycles got %0d exp %0d", ken, KC); end
    vecs++;
    if ({busy, kern_enable, pix_in_ready} !== 3'b101) begin
      errs++;
      $display("FAIL run_state got busy/ken/rdy=%b exp 101", {busy, kern_enable, pix_in_ready});
    end
  endtask

  task automatic test_stream();
    do_reset();
    run_frame(0, 0, 0, 0, 2000);
    vecs++;
    if (r_nwin != 48) begin errs++; $display("FAIL stream_windows got %0d exp 48", r_nwin); end
    vecs++;
    if (r_first_acc < 19 || r_first_acc > 20) begin
      errs++; $display("FAIL first_window got after %0d pixels exp 19..20", r_first_acc);
    end
    vecs++;
    if (r_krst != 1 || r_ken != KC) begin
      errs++; $display("FAIL stream_kern got krst=%0d ken=%0d exp 1 %0d", r_krst, r_ken, KC);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done === 1'b1) r_ndone++;
    end
    vecs++;
    if (r_ndone != 1 || busy !== 1'b0) begin
      errs++; $display("FAIL done_pulse got %0d busy=%b exp 1 busy=0", r_ndone, busy);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    run_frame(2, 0, 0, 1, 60);
    vecs++;
    if (r_acc != 24) begin errs++; $display("FAIL bp_accepted got %0d exp 24", r_acc); end
    vecs++;
    if (r_row3 != 0 || pix_in_ready !== 1'b0) begin
      errs++; $display("FAIL bp_row3 got writes=%0d rdy=%b exp 0 0", r_row3, pix_in_ready);
    end
    vecs++;
    if ({win_valid, win_x, win_y} !== 7'b1_000_000) begin
      errs++; $display("FAIL bp_window got v=%b (%0d,%0d) exp v=1 (0,0)", win_valid, win_x, win_y);
    end
  endtask

  task automatic test_random_stall();
    do_reset();
    run_frame(1, 0, 0, 0, 4000);
    vecs++;
    if (r_nwin != 48 || exp_q.size() != 0) begin
      errs++; $display("FAIL rand_windows got %0d left=%0d exp 48 0", r_nwin, exp_q.size());
    end
    vecs++;
    if (r_stalls == 0) begin errs++; $display("FAIL rand_stalls got 0 exp >0"); end
  endtask

  task automatic test_midframe_reset();
    do_reset();
    run_frame(0, 0, 1, 0, 2000);
    #1;
    vecs++;
    if (r_aborted != 1 || outs !== '0) begin
      errs++; $display("FAIL abort_outs got aborted=%0d outs=%h exp 1 0", r_aborted, outs);
    end
    repeat (2) @(negedge clk);
    vecs++;
    if (outs !== '0) begin errs++; $display("FAIL abort_hold got %h exp 0", outs); end
    @(posedge clk); #1 rst_n = 1'b1;
    run_frame(0, 0, 0, 0, 2000);
    vecs++;
    if (r_nwin != 48 || r_ndone != 1 || exp_q.size() != 0) begin
      errs++; $display("FAIL rerun got win=%0d done=%0d exp 48 1", r_nwin, r_ndone);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_frame(0, 1, 0, 0, 2000);
    vecs++;
    if (r_nwin != 48) begin errs++; $display("FAIL b2b_first got %0d exp 48", r_nwin); end
    @(negedge clk);
    vecs++;
    if (busy !== 1'b0) begin errs++; $display("FAIL b2b_idle got busy=%b exp 0", busy); end
    @(negedge clk);
    vecs++;
    if (kern_reset !== 1'b1) begin errs++; $display("FAIL b2b_restart got krst=%b exp 1", kern_reset); end
    run_frame(0, 0, 0, 0, 2000);
    vecs++;
    if (r_nwin != 48 || r_ndone != 1) begin
      errs++; $display("FAIL b2b_second got win=%0d done=%0d exp 48 1", r_nwin, r_ndone);
    end
  endtask

  initial begin
    test_reset();
    test_kgen();
    test_stream();
    test_backpressure();
    test_random_stall();
    test_midframe_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
